nlm_pe_sched: RTL and testbench

- Frame-level scheduler for the NLM PE systolic chain.
- Accepts a raster pixel stream through a valid/ready handshake and pre-fills the line buffers that feed total/srh/ref blocks.
- Drives the chain-enable, zero-injection and result-valid strobes, then flushes the pipeline.
- Sits between the input line-buffer bank and the PE chain head/tail; the divider consumes pe_out_valid_o.

---
 rtl/nlm_pe_sched.sv | 156 +++++++++++++++
 tb/tb_nlm_pe_sched.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nlm_pe_sched.sv
// Frame scheduler for the NLM PE systolic chain.
// Pre-fills line buffers, drives chain strobes, then flushes.
module nlm_pe_sched #(
  parameter int IMG_WIDTH    = 64,
  parameter int IMG_HEIGHT   = 48,
  parameter int TOTAL_LENGTH = 17,
  parameter int PIPE_LAT     = 20,
  parameter int CNT_W        = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic                          pix_valid_i,
  output logic                          pix_ready_o,
  output logic                          lb_wr_en_o,
  output logic                          pe_en_o,
  output logic                          sum_clr_o,
  output logic                          pe_out_valid_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int FW = $clog2(PIPE_LAT+1);
  localparam int FILL_PIX  = (TOTAL_LENGTH-1)*IMG_WIDTH;
  localparam int TOTAL_PIX = IMG_WIDTH*IMG_HEIGHT;
  localparam bit NO_RUN = FILL_PIX >= TOTAL_PIX;
  localparam logic [CNT_W-1:0] FILL_END =
    CNT_W'(NO_RUN ? TOTAL_PIX : FILL_PIX);
  localparam logic [CNT_W-1:0] TOT_END = CNT_W'(TOTAL_PIX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CW-1:0]     r_ncol;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_nrow;
  logic [RW-1:0]     r_row;
  logic [FW-1:0]     r_fcnt;
  logic [PIPE_LAT-1:0] r_tag;

  logic              w_fill;
  logic              w_run;
  logic              w_flush;
  logic              w_ready;
  logic              w_acc;
  logic              w_pe_en;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PIPE_LAT:0] w_tag_nxt;

  assign w_fill    = (r_state == S_FILL);
  assign w_run     = (r_state == S_RUN);
  assign w_flush   = (r_state == S_FLUSH);
  assign w_ready   = w_fill | w_run;
  assign w_acc     = pix_valid_i & w_ready;
  assign w_pe_en   = (w_run & w_acc) | w_flush;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  // Real pixels enter with tag 1, flush bubbles with tag 0.
  assign w_tag_nxt = {r_tag, w_run};

  assign pix_ready_o    = w_ready;
  assign lb_wr_en_o     = w_acc;
  assign pe_en_o        = w_pe_en;
  assign sum_clr_o      = w_pe_en;
  assign pe_out_valid_o = r_tag[PIPE_LAT-1] & w_pe_en;
  assign col_o          = r_col;
  assign row_o          = r_row;
  assign busy_o         = (r_state != S_IDLE);
  assign done_o         = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ncol  <= '0;
      r_col   <= '0;
      r_nrow  <= '0;
      r_row   <= '0;
      r_fcnt  <= '0;
      r_tag   <= '0;
    end else if (abort_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ncol  <= '0;
      r_col   <= '0;
      r_nrow  <= '0;
      r_row   <= '0;
      r_fcnt  <= '0;
      r_tag   <= '0;
    end else begin
      if (w_pe_en) begin
        r_tag <= w_tag_nxt[PIPE_LAT-1:0];
      end
      if (w_acc) begin
        r_cnt <= w_cnt_nxt;
        r_col <= r_ncol;
        r_row <= r_nrow;
        if (r_ncol == CW'(IMG_WIDTH-1)) begin
          r_ncol <= '0;
          r_nrow <= r_nrow + RW'(1);
        end else begin
          r_ncol <= r_ncol + CW'(1);
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= (FILL_PIX == 0) ? S_RUN : S_FILL;
            r_cnt   <= '0;
            r_ncol  <= '0;
            r_col   <= '0;
            r_nrow  <= '0;
            r_row   <= '0;
            r_fcnt  <= '0;
            r_tag   <= '0;
          end
        end
        S_FILL: begin
          if (w_acc && (w_cnt_nxt == FILL_END)) begin
            r_state <= NO_RUN ? S_FLUSH : S_RUN;
          end
        end
        S_RUN: begin
          if (w_acc && (w_cnt_nxt == TOT_END)) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == FW'(PIPE_LAT-1)) begin
            r_state <= S_DONE;
          end else begin
            r_fcnt <= r_fcnt + FW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nlm_pe_sched.sv
// Bench for nlm_pe_sched: frame table, count-based model,
// async reset mid-flush and a fill-only frame.
module tb_nlm_pe_sched;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int TL   = 3;
  localparam int PL   = 4;
  localparam int FILL = (TL-1)*W;
  localparam int TOT  = W*H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start7 = 1'b0;
  logic abort = 1'b0;
  logic valid = 1'b0;

  logic rdy, wr, pe, clr, ov, busy, done;
  logic [2:0] col, row;
  logic rdy7, wr7, pe7, clr7, ov7, busy7, done7;
  logic [2:0] col7, row7;

  always #5 clk = ~clk;

  nlm_pe_sched #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .TOTAL_LENGTH(TL), .PIPE_LAT(PL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .start_i(start), .abort_i(abort),
    .pix_valid_i(valid), .pix_ready_o(rdy),
    .lb_wr_en_o(wr), .pe_en_o(pe),
    .sum_clr_o(clr), .pe_out_valid_o(ov),
    .col_o(col), .row_o(row),
    .busy_o(busy), .done_o(done)
  );

  nlm_pe_sched #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .TOTAL_LENGTH(7), .PIPE_LAT(PL)
  ) u_dut7 (
    .clk(clk), .rst_n(rst_n),
    .start_i(start7), .abort_i(abort),
    .pix_valid_i(valid), .pix_ready_o(rdy7),
    .lb_wr_en_o(wr7), .pe_en_o(pe7),
    .sum_clr_o(clr7), .pe_out_valid_o(ov7),
    .col_o(col7), .row_o(row7),
    .busy_o(busy7), .done_o(done7)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, want %0d",
                  name, $time, act, exp);
  endtask

  // Model: frame position as counts, tags as one entry per chain step.
  bit m_busy = 1'b0;
  int m_n = 0;
  int m_f = 0;
  bit m_q[$];
  int f_pulses, f_busy, f_done;

  task automatic step(input bit wrapchk);
    bit e_rdy, e_acc, e_run, e_fl, e_dn, e_pe, e_ov;
    int qs;
    e_rdy = m_busy && (m_n < TOT);
    e_acc = valid && e_rdy;
    e_run = m_busy && (m_n >= FILL) && (m_n < TOT);
    e_fl  = m_busy && (m_n == TOT) && (m_f < PL);
    e_dn  = m_busy && (m_n == TOT) && (m_f == PL);
    e_pe  = (e_run && e_acc) || e_fl;
    qs    = m_q.size();
    e_ov  = e_pe && (qs >= PL) && m_q[qs-PL];
    chk("ready", rdy, e_rdy);
    chk("wr_en", wr, e_acc);
    chk("pe_en", pe, e_pe);
    chk("sum_clr", clr, e_pe);
    chk("out_valid", ov, e_ov);
    chk("busy", busy, m_busy);
    chk("done", done, e_dn);
    chk("col", col, (m_n == 0) ? 0 : (m_n-1) % W);
    chk("row", row, (m_n == 0) ? 0 : (m_n-1) / W);
    if (wrapchk && m_n == 9) begin
      chk("wrap_col", col, 0);
      chk("wrap_row", row, 1);
    end
    if (wrapchk && m_busy && m_n == TOT && m_f == 0) begin
      chk("last_col", col, 7);
      chk("last_row", row, 5);
    end
    f_pulses += int'(ov);
    f_busy   += int'(busy);
    f_done   += int'(done);
    if (abort) begin
      m_busy = 1'b0; m_n = 0; m_f = 0; m_q.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1; m_n = 0; m_f = 0; m_q.delete();
      end
    end else begin
      if (e_pe) m_q.push_back(e_run);
      if (e_acc) m_n++;
      if (e_fl) m_f++;
      if (e_dn) m_busy = 1'b0;
    end
  endtask

  typedef struct {
    int mode;
    int abort_at;
    int exp_pulses;
    int exp_done;
    int exp_busy;
    bit wrapchk;
  } frame_t;

  task automatic run_frame(input frame_t fr);
    bit fin;
    fin = 1'b0;
    f_pulses = 0; f_busy = 0; f_done = 0;
    @(posedge clk); #1;
    start = 1'b1; valid = 1'b0; abort = 1'b0;
    @(negedge clk); step(fr.wrapchk);
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      case (fr.mode)
        0: valid = 1'b1;
        1: valid = (c % 2 == 0);
        default: valid = 1'($urandom_range(0, 1));
      endcase
      abort = (fr.abort_at >= 0) && (m_n == fr.abort_at) && valid;
      @(negedge clk); step(fr.wrapchk);
      if (!m_busy) fin = 1'b1;
    end
    @(posedge clk); #1;
    abort = 1'b0; valid = 1'b0;
    chk("frame_end", fin, 1);
    chk("pulses", f_pulses, fr.exp_pulses);
    chk("dones", f_done, fr.exp_done);
    if (fr.exp_busy >= 0) chk("busy_cycles", f_busy, fr.exp_busy);
  endtask

  frame_t frames[6];
  int a7, pe_fill7, pe7_n, ov7_n, done7_n, busy7_n;
  bit fin7;

  initial begin
    frames[0] = '{0, -1, 32, 1, 53, 1'b1};
    frames[1] = '{1, -1, 32, 1, 100, 1'b0};
    frames[2] = '{0, 25, 6, 0, 26, 1'b0};
    frames[3] = '{0, -1, 32, 1, 53, 1'b1};
    frames[4] = '{2, -1, 32, 1, -1, 1'b0};
    frames[5] = '{2, -1, 32, 1, -1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    step(1'b0);
    chk("rst_busy7", busy7, 0);
    chk("rst_pe7", pe7, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(frames[i]);

    // Mid-frame start is ignored; reset lands in FLUSH.
    @(posedge clk); #1;
    start = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy, 1);
    chk("restart_col", col, 4);
    chk("restart_row", row, 2);
    repeat (28) @(posedge clk);
    @(negedge clk);
    chk("flush_pe_en", pe, 1);
    chk("flush_ready", rdy, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", rdy, 0);
    chk("arst_wr", wr, 0);
    chk("arst_pe", pe, 0);
    chk("arst_clr", clr, 0);
    chk("arst_ov", ov, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_col", col, 0);
    chk("arst_row", row, 0);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_busy = 1'b0; m_n = 0; m_f = 0; m_q.delete();
    @(negedge clk); step(1'b0);

    // Fill covers the whole frame: no RUN, flush only.
    a7 = 0; pe_fill7 = 0; pe7_n = 0;
    ov7_n = 0; done7_n = 0; busy7_n = 0; fin7 = 1'b0;
    @(posedge clk); #1;
    start7 = 1'b1; valid = 1'b1;
    @(posedge clk); #1;
    start7 = 1'b0;
    for (int c = 0; c < 200 && !fin7; c++) begin
      @(negedge clk);
      if (!busy7) fin7 = 1'b1;
      else begin
        busy7_n++;
        a7 += int'(rdy7 & valid);
        pe_fill7 += int'(rdy7 & pe7);
        pe7_n += int'(pe7);
        ov7_n += int'(ov7);
        done7_n += int'(done7);
        @(posedge clk); #1;
      end
    end
    valid = 1'b0;
    chk("f7_end", fin7, 1);
    chk("f7_accepts", a7, 48);
    chk("f7_pe_in_fill", pe_fill7, 0);
    chk("f7_pe_total", pe7_n, 4);
    chk("f7_pulses", ov7_n, 0);
    chk("f7_dones", done7_n, 1);
    chk("f7_busy", busy7_n, 53);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
